// File: rtl/keccak_perm_ctrl.sv
// Keccak-f[1600] round sequencer: holds the state and iterates an external round datapath.
// Optional abort input enabled by defining KECCAK_ABORT_EN.
module keccak_perm_ctrl #(
  parameter int unsigned NR = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:4][0:4][63:0]   A_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [0:4][0:4][63:0]   A_out,
  output logic [0:4][0:4][63:0]   rnd_A_o,
  output logic [4:0]              rnd_ir_o,
  input  logic [0:4][0:4][63:0]   rnd_A_i,
`ifdef KECCAK_ABORT_EN
  input  logic                    abort,
`endif
  output logic                    busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [4:0] LastRnd = 5'(NR - 1);

  state_e                  state_q, state_d;
  logic [0:4][0:4][63:0]   s_q, s_d;
  logic [4:0]              r_q, r_d;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    r_d     = r_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          s_d     = A_in;
          r_d     = 5'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        s_d = rnd_A_i;
        if (r_q == LastRnd) begin
          r_d     = 5'd0;
          state_d = StDone;
        end else begin
          r_d = r_q + 5'd1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef KECCAK_ABORT_EN
    // Abort drops the permutation but keeps S; rst still wins in the register process.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      s_d     = s_q;
      r_d     = 5'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      s_q     <= '0;
      r_q     <= 5'd0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      r_q     <= r_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign out_valid = (state_q == StDone);
  assign A_out     = s_q;
  assign rnd_A_o   = s_q;
  assign rnd_ir_o  = r_q;

endmodule

// File: doc/keccak_perm_ctrl.md
# keccak_perm_ctrl

Sequencer for the Keccak-f[1600] permutation in the SHAKE256 core. It holds the 5×5×64-bit state register and steps it through NR rounds of the team's external combinational round datapath, one round per cycle, driving the round index. It accepts a state with a valid/ready handshake and returns the permuted state the same way. It sits between the sponge absorb/squeeze logic and the round datapath.

## Interface
Parameters:
- NR, default 24: rounds per permutation; legal range 1..32.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  A_in is valid; request to start a permutation.
- in_ready  out  1  block can accept A_in (high only in IDLE).
- A_in  in  [63:0] [0:4][0:4]  state to permute, lane [x][y].
- out_valid  out  1  A_out holds the permuted state.
- out_ready  in  1  consumer takes A_out.
- A_out  out  [63:0] [0:4][0:4]  permuted state (state register).
- rnd_A_o  out  [63:0] [0:4][0:4]  state fed to the round datapath (equals state register).
- rnd_ir_o  out  5  round index for the datapath.
- rnd_A_i  in  [63:0] [0:4][0:4]  combinational round-datapath result.
- busy  out  1  high in RUN.

## Operation
- State register S (1600 bits) and round counter R (5 bits). FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid: S<=A_in, R<=0, go to RUN. Without in_valid: hold.
- RUN: S<=rnd_A_i, R<=R+1 every cycle. On the edge where R==NR-1: go to DONE, R<=0. in_valid is ignored (in_ready=0).
- DONE: out_valid=1, A_out=S held stable until out_ready. On out_ready: go to IDLE. S is not cleared.
- rnd_A_o=S and rnd_ir_o=R in every state. The datapath result is used only in RUN.
- No back-to-back overlap: a new input is accepted only from IDLE, at least one cycle after the DONE handshake.
- R never exceeds NR-1. There is no wrap-around other than the reset to 0 on the RUN→DONE edge.

## Timing
- Reset values: FSM=IDLE, S=0, R=0. Outputs: in_ready=1, out_valid=0, busy=0, A_out=0, rnd_A_o=0, rnd_ir_o=0.
- rst mid-RUN or mid-DONE returns to the reset values at the next edge; the in-flight result is discarded. rst takes priority over all inputs.
- Latency: input accepted at edge t0 → out_valid rises after edge t0+NR (24 by default).
- Throughput: one permutation per NR+2 cycles with out_ready held high.
- All outputs come directly from registers or the FSM decode. There is no combinational path from in_valid or out_ready to any output.
- rnd_A_i must settle within one cycle. The round datapath is purely combinational; its path delay is the critical path.

## Configuration
- KECCAK_ABORT_EN defined: adds input port abort (1 bit).
  - abort=1 in RUN or DONE forces IDLE at the next edge with R<=0 and S unchanged. No out_valid is produced for that permutation.
  - abort in IDLE has no effect.
  - rst takes priority over abort.
- KECCAK_ABORT_EN undefined: no abort port. RUN always completes NR rounds.

## Test plan
- Stub datapath: rnd_A_i = rnd_A_o with lane[0][0]+1. Input all-zero. → out_valid asserts 24 cycles after accept; A_out[0][0]=64'h18; other lanes 0; rnd_ir_o steps 0..23 during RUN.
- Real round datapath, all-zero input → A_out[0][0]=64'hF1258F7940E1DDE7 (Keccak-f[1600] reference vector).
- out_ready held low 10 cycles in DONE → A_out stable, out_valid stays 1, in_ready=0; in_valid pulses during that window are ignored.
- rst asserted at round 12 → next cycle IDLE, in_ready=1, R=0, S=0; a new permutation then completes correctly.
- in_valid held high continuously with out_ready=1 → accepts spaced exactly 26 cycles apart.
- With KECCAK_ABORT_EN: abort at round 5 → IDLE next cycle, out_valid never asserts; a following request completes with the correct result.
